// File: rtl/scroll_image_source.sv
// scroll_image_source: message buffer plus scrolling 5-column window that
// feeds the 5x7 column-scanned matrix displayer.
//
// The message lives in a small column buffer written over wr_en/wr_addr/wr_data.
// A free-running prescaler produces a scroll tick every TICK_DIV clocks. On each
// tick, while enable is high, the window offset moves one column up (down=0) or
// down (down=1) modulo the effective message length. The registered image
// output always shows the five columns starting at the current offset, taken
// modulo the effective length, so short messages repeat across the window.
//
// Optional feature, macro SCROLL_IMAGE_BLINK_EN: adds a blink input and a
// blink phase that toggles on every tick; while blink is high and the phase is
// set, the image is blanked. Offset and frame_tick are not affected.
module scroll_image_source #(
    parameter int COLUNE_SIZE   = 7,
    parameter int TOTAL_COLUNES = 5,
    parameter int DATA_WIDTH    = 35,
    parameter int MSG_COLUNES   = 16,
    parameter int TICK_DIV      = 12500000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           down,
`ifdef SCROLL_IMAGE_BLINK_EN
    input  logic                           blink,
`endif
    input  logic [$clog2(MSG_COLUNES):0]   msg_len,
    input  logic                           wr_en,
    input  logic [$clog2(MSG_COLUNES)-1:0] wr_addr,
    input  logic [COLUNE_SIZE-1:0]         wr_data,
    output logic [DATA_WIDTH-1:0]          image,
    output logic                           frame_tick
);

    // Buffer address width, and a wider index width so offset+k and Le-1
    // never overflow.
    localparam int AW = $clog2(MSG_COLUNES);
    localparam int IW = AW + 3;
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]          prescaler_q, prescaler_d;
    logic [IW-1:0]          offset_q, offset_d;
    logic [DATA_WIDTH-1:0]  image_q, image_d;
    logic                   frame_tick_q, frame_tick_d;
    logic [COLUNE_SIZE-1:0] msg_buf_q [MSG_COLUNES];
    logic [COLUNE_SIZE-1:0] msg_buf_d [MSG_COLUNES];
`ifdef SCROLL_IMAGE_BLINK_EN
    logic                   blink_phase_q, blink_phase_d;
`endif

    logic [IW-1:0]          le;
    logic                   tick;
    logic                   advance;
    logic [IW-1:0]          offset_inc;
    logic [IW-1:0]          offset_step;
    logic [AW-1:0]          col_idx;
    logic [DATA_WIDTH-1:0]  window;

    // Effective length, prescaler, offset stepping, frame pulse and buffer writes.
    always_comb begin
        // A length of zero or beyond the buffer depth means "whole buffer".
        le = IW'(MSG_COLUNES);
        if (msg_len != '0 && IW'(msg_len) <= IW'(MSG_COLUNES)) begin
            le = IW'(msg_len);
        end

        tick        = (prescaler_q == PW'(TICK_DIV - 1));
        prescaler_d = tick ? '0 : prescaler_q + PW'(1);
        advance     = tick & enable;

        // An offset left beyond Le by a shrinking msg_len is pulled back here
        // on the next advance, in either direction.
        offset_inc = offset_q + IW'(1);
        if (down) begin
            offset_step = (offset_q == '0 || offset_q >= le) ? le - IW'(1)
                                                              : offset_q - IW'(1);
        end else begin
            offset_step = (offset_inc >= le) ? '0 : offset_inc;
        end
        offset_d = advance ? offset_step : offset_q;

        // Wrap detection: landing on the first column going up, or on the last
        // column going down.
        frame_tick_d = advance & (down ? (offset_step == le - IW'(1))
                                       : (offset_step == '0));

        msg_buf_d = msg_buf_q;
        if (wr_en) begin
            msg_buf_d[wr_addr] = wr_data;
        end

`ifdef SCROLL_IMAGE_BLINK_EN
        blink_phase_d = tick ? ~blink_phase_q : blink_phase_q;
`endif
    end

    // Window assembly from the current offset and current (pre-write) buffer.
    always_comb begin
        window  = '0;
        col_idx = '0;
        for (int k = 0; k < TOTAL_COLUNES; k++) begin
            col_idx = AW'((offset_q + IW'(k)) % le);
            window[k*COLUNE_SIZE +: COLUNE_SIZE] = msg_buf_q[col_idx];
        end
        image_d = window;
`ifdef SCROLL_IMAGE_BLINK_EN
        if (blink && blink_phase_q) begin
            image_d = '0;
        end
`endif
    end

    // State registers; reset clears everything including the message buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q  <= '0;
            offset_q     <= '0;
            image_q      <= '0;
            frame_tick_q <= 1'b0;
            for (int i = 0; i < MSG_COLUNES; i++) begin
                msg_buf_q[i] <= '0;
            end
`ifdef SCROLL_IMAGE_BLINK_EN
            blink_phase_q <= 1'b0;
`endif
        end else begin
            prescaler_q  <= prescaler_d;
            offset_q     <= offset_d;
            image_q      <= image_d;
            frame_tick_q <= frame_tick_d;
            msg_buf_q    <= msg_buf_d;
`ifdef SCROLL_IMAGE_BLINK_EN
            blink_phase_q <= blink_phase_d;
`endif
        end
    end

    assign image      = image_q;
    assign frame_tick = frame_tick_q;

endmodule
